// File: rtl/adrv9001_tx_serdes_core.sv
// TX framing core for the ADRV9001 LSSI data port: buffers AXI-Stream I/Q samples
// and slices each one into per-clock data/Q/strobe lane words for the OSERDES.
module adrv9001_tx_serdes_core #(
    parameter int SERDES_WIDTH = 8,
    parameter int FIFO_DEPTH   = 8,
    parameter int STROBE_MODE  = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          lane_mode,
    input  logic [31:0]                   s_axis_tdata,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    output logic [SERDES_WIDTH-1:0]       idata_word,
    output logic [SERDES_WIDTH-1:0]       qdata_word,
    output logic [SERDES_WIDTH-1:0]       strobe_word,
    output logic                          word_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   underflow_cnt
);
    localparam int W  = SERDES_WIDTH;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int N2 = 16 / W;
    localparam int N1 = 32 / W;
    localparam int SW = $clog2(N1);

    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]   count_reg, count_next;
    logic          ready_reg;

    logic [SW-1:0] slot_reg, slot_next, last_slot;
    logic          mode_reg, mode_next, cur_mode;
    logic [31:0]   shift_reg, shift_next, src;
    logic [15:0]   uf_reg, uf_next;
    logic [W-1:0]  idata_reg, idata_next;
    logic [W-1:0]  qdata_reg, qdata_next;
    logic [W-1:0]  strobe_reg, strobe_next;
    logic          valid_reg, valid_next;

    logic push, pop, boundary;

    assign push     = s_axis_tvalid && ready_reg;
    assign boundary = enable && (slot_reg == '0);
    assign pop      = boundary && (count_reg != '0);

    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + 1'b1;
        end else if (!push && pop) begin
            count_next = count_reg - 1'b1;
        end
    end

    // The word selected here is registered straight into the lane outputs, so a
    // sample popped at a boundary shows its first word on the following cycle.
    always_comb begin
        src         = shift_reg;
        cur_mode    = mode_reg;
        last_slot   = '0;
        slot_next   = '0;
        shift_next  = shift_reg;
        mode_next   = mode_reg;
        uf_next     = uf_reg;
        idata_next  = '0;
        qdata_next  = '0;
        strobe_next = '0;
        valid_next  = 1'b0;
        if (enable) begin
            if (boundary) begin
                cur_mode  = lane_mode;
                mode_next = lane_mode;
                src       = pop ? mem[rd_ptr_reg] : 32'h0;
                if (!pop && (uf_reg != 16'hFFFF)) begin
                    uf_next = uf_reg + 16'd1;
                end
            end
            last_slot  = cur_mode ? SW'(N1 - 1) : SW'(N2 - 1);
            slot_next  = (slot_reg == last_slot) ? '0 : slot_reg + 1'b1;
            idata_next = src[31 -: W];
            if (cur_mode) begin
                shift_next = {src[31-W:0], {W{1'b0}}};
            end else begin
                qdata_next = src[15 -: W];
                shift_next = {src[31-W:16], {W{1'b0}}, src[15-W:0], {W{1'b0}}};
            end
            if (STROBE_MODE == 0) begin
                strobe_next = (slot_reg == '0) ? {1'b1, {(W-1){1'b0}}} : {W{1'b0}};
            end else begin
                // Half a sample period: 16 bit-times in 1-lane, 8 in 2-lane.
                strobe_next = ((int'(slot_reg) * W) < (cur_mode ? 16 : 8)) ? {W{1'b1}} : {W{1'b0}};
            end
            valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr_reg] <= s_axis_tdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ready_reg  <= 1'b0;
            slot_reg   <= '0;
            mode_reg   <= lane_mode;
            shift_reg  <= '0;
            uf_reg     <= '0;
            idata_reg  <= '0;
            qdata_reg  <= '0;
            strobe_reg <= '0;
            valid_reg  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg  <= count_next;
            // Ready follows the post-update level, so a pop while full only
            // re-opens the input on the next cycle.
            ready_reg  <= (count_next != (AW+1)'(FIFO_DEPTH));
            slot_reg   <= slot_next;
            mode_reg   <= mode_next;
            shift_reg  <= shift_next;
            uf_reg     <= uf_next;
            idata_reg  <= idata_next;
            qdata_reg  <= qdata_next;
            strobe_reg <= strobe_next;
            valid_reg  <= valid_next;
        end
    end

    assign s_axis_tready = ready_reg;
    assign idata_word    = idata_reg;
    assign qdata_word    = qdata_reg;
    assign strobe_word   = strobe_reg;
    assign word_valid    = valid_reg;
    assign fifo_level    = count_reg;
    assign underflow_cnt = uf_reg;

endmodule

// File: doc/adrv9001_tx_serdes_core.md
Name: adrv9001_tx_serdes_core

Overview:
Parametrised TX framing core for the ADRV9001 LSSI data port. It buffers AXI-Stream I/Q samples in a small FIFO and emits per-clock parallel bit words for the data, Q and strobe lanes; the IO wrapper's OSERDES consumes these words. It generalises the fixed 32-bit 2-lane TX path with several additions:
- configurable SERDES width and FIFO depth
- runtime 1-lane/2-lane selection
- two strobe formats
- deterministic underflow fill and underflow counting

Parameters:
SERDES_WIDTH, 8, bits per lane per clk; 4 or 8; must divide 16.
FIFO_DEPTH, 8, sample FIFO entries; power of 2, 4..64.
STROBE_MODE, 0, 0 = strobe high for the first bit of each sample only; 1 = strobe high for the first half of each sample period.

Ports:
clk  in  1  core clock (SERDES parallel-side clock)
rst  in  1  synchronous reset, active-high
enable  in  1  1 = stream to the lanes; 0 = lanes idle
lane_mode  in  1  0 = 2-lane (I on idata, Q on qdata); 1 = 1-lane (I then Q on idata)
s_axis_tdata  in  32  [31:16] = I, [15:0] = Q
s_axis_tvalid  in  1  sample valid
s_axis_tready  out  1  FIFO can accept a sample
idata_word  out  SERDES_WIDTH  data-lane bits; MSB transmitted first
qdata_word  out  SERDES_WIDTH  Q-lane bits; MSB transmitted first
strobe_word  out  SERDES_WIDTH  strobe-lane bits; MSB transmitted first
word_valid  out  1  high while words belong to an active sample period
fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy
underflow_cnt  out  16  count of zero-filled sample periods, saturating

Behaviour:
- Reset values: all word outputs 0, word_valid 0, fifo_level 0, underflow_cnt 0, s_axis_tready 0 during rst and 1 the cycle after. FIFO is emptied, slot counter = 0, latched mode = lane_mode.
- FIFO:
  - write on tvalid & tready; tready = !full.
  - read only at a sample boundary (see below).
  - a simultaneous write and read when full is not accepted: tready is low when full, regardless of a same-cycle pop.
  - fifo_level is registered and reflects writes and pops of the previous cycle.
- Sample period N:
  - 2-lane: N = 16/SERDES_WIDTH.
  - 1-lane: N = 32/SERDES_WIDTH.
  - slot counter runs 0..N-1 and wraps.
- Boundary = slot 0 with enable = 1. At a boundary:
  - latch lane_mode.
  - if the FIFO is non-empty, pop the head into the shift register; otherwise load 0x00000000 and increment underflow_cnt (holds at 0xFFFF).
- Outputs are registered. A sample popped in cycle t drives its first word in cycle t+1; consecutive words follow with no gaps; the next sample's first word directly follows the last word.
- 2-lane: idata_word = I[15:0] and qdata_word = Q[15:0], each sliced MSB-first across N words.
- 1-lane: idata_word = {I,Q} sliced MSB-first across N words; qdata_word = 0.
- Strobe:
  - mode 0: the first word of each sample has MSB = 1, all other strobe bits 0.
  - mode 1: strobe bits are 1 for the first 16 bit-times of a 1-lane sample, or the first 8 bit-times of a 2-lane sample, and 0 after.
  - strobe runs during underflow exactly as for real data.
- enable = 0:
  - slot counter held at 0, no pops, no underflow counting.
  - word outputs and word_valid are 0 from the next cycle.
  - a deassertion mid-sample abandons the remainder of that sample (it is not re-sent).
- enable rising: the first boundary is in the same cycle; the first word appears in the next cycle.
- lane_mode change mid-sample: ignored until the next boundary; the current sample completes in the old mode.
- rst mid-stream: the in-flight sample and FIFO contents are discarded; outputs are 0 in the cycle after rst is sampled.

Test Plan:
1. SERDES_WIDTH=8, STROBE_MODE=0, 2-lane; push 0x12345678, then enable -> idata 0x12,0x34; qdata 0x56,0x78; strobe 0x80,0x00; word_valid 1,1; underflow_cnt stays 0 while the FIFO is fed.
2. 1-lane, STROBE_MODE=1; push 0xAA015502 -> idata 0xAA,0x01,0x55,0x02; qdata 0x00 x4; strobe 0xFF,0xFF,0x00,0x00.
3. enable=1 with an empty FIFO for 3 sample periods (2-lane) -> idata/qdata 0x00; strobe 0x80,0x00 repeating; underflow_cnt = 3; then push 0x32324545 -> idata 0x32,0x32 and qdata 0x45,0x45 at the next boundary.
4. FIFO_DEPTH=4, enable=0; hold tvalid for 6 cycles -> 4 accepted, tready 0 from the 5th, fifo_level = 4; enable -> samples emitted in order, tready returns 1 after the first pop.
5. Toggle lane_mode at slot 1 of a 2-lane sample -> that sample finishes as 2 words; the next sample is 4 words in 1-lane format.
6. Assert rst during slot 1 with 3 samples queued -> next-cycle outputs 0, fifo_level 0, underflow_cnt 0, tready 1 after rst drops.
